// File: rtl/ram32x4_arbiter.sv
// ram32x4_arbiter: shares one single-port synchronous RAM between requesters A
// and B with round-robin arbitration, and sweeps CLEAR_VALUE into every word
// on demand.
module ram32x4_arbiter #(
  parameter int unsigned       ADDR_W      = 5,
  parameter int unsigned       DATA_W      = 4,
  parameter int unsigned       DEPTH       = 32,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              ack_b,
  output logic [DATA_W-1:0] rdata,
  input  logic              clear_start,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_ACK    = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic              ack_a_q, ack_a_d;
  logic              ack_b_q, ack_b_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  // 1 = B was granted most recently; also identifies the in-flight winner
  logic              last_grant_q, last_grant_d;
  logic              grant_b;

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    ack_a_d       = 1'b0;
    ack_b_d       = 1'b0;
    rdata_d       = rdata_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = ram_wren_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    grant_b       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear_start) begin
          state_d       = S_CLEAR;
          cnt_d         = '0;
          ram_address_d = '0;
          ram_data_d    = CLEAR_VALUE;
          ram_wren_d    = 1'b1;
        end else if (req_a || req_b) begin
          // On a tie the requester not granted last time wins
          grant_b       = req_b && (!req_a || !last_grant_q);
          last_grant_d  = grant_b;
          ram_address_d = grant_b ? addr_b : addr_a;
          ram_data_d    = grant_b ? wdata_b : wdata_a;
          ram_wren_d    = grant_b ? we_b : we_a;
          state_d       = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (ram_wren_q) begin
          ram_wren_d = 1'b0;
          ack_a_d    = !last_grant_q;
          ack_b_d    = last_grant_q;
          state_d    = S_ACK;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        rdata_d = ram_q;
        ack_a_d = !last_grant_q;
        ack_b_d = last_grant_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          ram_wren_d = 1'b0;
          cnt_d      = '0;
          state_d    = S_IDLE;
        end else begin
          cnt_d         = cnt_q + ADDR_W'(1);
          ram_address_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ack_a_q       <= 1'b0;
      ack_b_q       <= 1'b0;
      rdata_q       <= '0;
      busy_q        <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      ack_a_q       <= ack_a_d;
      ack_b_q       <= ack_b_d;
      rdata_q       <= rdata_d;
      busy_q        <= busy_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;

endmodule
